// File: rtl/foo_adder.sv
// foo_adder: registered two-operand unsigned adder, c = (a + b) mod 2^WIDTH.
//
// Parameters
//   WIDTH  operand/result width (1..64), default 8
//
// Ports
//   clock  rising-edge clock
//   reset  asynchronous active-low reset; clears every result register
//   a, b   unsigned operands, sampled on each rising edge
//   c      registered sum, truncated to WIDTH bits
//
// Build option
//   FOO_ADDER_PIPE2_EN  adds a second register after the sum register.
//                       Latency goes from 1 to 2 clocks. Throughput stays
//                       at one result per clock.

module foo_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c
);

  // The add is sized to WIDTH on purpose. The carry-out would be dropped
  // anyway, so c wraps modulo 2^WIDTH. There is no saturation and no
  // overflow flag.
  logic [WIDTH-1:0] sum;
  assign sum = a + b;

`ifdef FOO_ADDER_PIPE2_EN
  logic [WIDTH-1:0] stage1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage1 <= '0;
      c      <= '0;
    end else begin
      stage1 <= sum;
      c      <= stage1;
    end
  end
`else
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) c <= '0;
    else        c <= sum;
  end
`endif

endmodule

// File: tb/tb_foo_adder.sv
// tb_foo_adder: self-checking bench for foo_adder (WIDTH=8).
//
// A scoreboard queue gets one expected sum for each rising edge that
// samples a/b. It also holds zero entries for the pipeline fill after
// reset. Each edge pops the value c must show next. Directed checks cover
// reset, wrap, async reset and between-edge stability. A 1000-cycle
// random stream follows.

module tb_foo_adder;
  localparam int W = 8;
`ifdef FOO_ADDER_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] c;

  foo_adder #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .a     (a),
    .b     (b),
    .c     (c)
  );

  always #5 clock = ~clock;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
  endtask

  // Scoreboard model
  logic [W-1:0] sb_q[$];
  logic [W-1:0] exp_c = '0;
  logic [W:0]   m_full;
  logic         sb_on = 1'b0;

  assign m_full = {1'b0, a} + {1'b0, b};

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      sb_q.delete();
      for (int i = 0; i < LAT - 1; i++) sb_q.push_back('0);
      exp_c <= '0;
    end else begin
      sb_q.push_back(m_full[W-1:0]);
      exp_c <= sb_q.pop_front();
    end
  end

  always @(negedge clock) if (sb_on) chk("sb", c, exp_c);

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic apply(input logic [W-1:0] va, input logic [W-1:0] vb,
                       input string tag, input logic [W-1:0] exp);
    a = va;
    b = vb;
    repeat (LAT) tick();
    chk(tag, c, exp);
  endtask

  initial begin
    // Reset held low while the clock runs: c must stay 0.
    #1 reset = 1'b0;
    a = 8'd3;
    b = 8'd4;
    repeat (3) begin
      tick();
      chk("rst_hold", c, 8'd0);
    end
    sb_on = 1'b1;
    reset = 1'b1;
    tick();
    chk("rst_rel_e1", c, (LAT == 1) ? 8'd7 : 8'd0);
    repeat (LAT - 1) tick();
    chk("rst_rel", c, 8'd7);

    // Basic adds, plus the hold of the old value before the next edge.
    apply(8'h12, 8'h34, "basic0", 8'h46);
    a = 8'd1;
    b = 8'd2;
    #1 chk("hold_pre", c, 8'h46);
    tick();
    chk("basic1_e1", c, (LAT == 1) ? 8'd3 : 8'h46);
    repeat (LAT - 1) tick();
    chk("basic1", c, 8'd3);

    // Boundaries and wrap-around.
    apply(8'h00, 8'h00, "zero",   8'h00);
    apply(8'hFF, 8'h01, "wrap1",  8'h00);
    apply(8'hFF, 8'hFF, "wrapff", 8'hFE);
    apply(8'h80, 8'h80, "wrap80", 8'h00);

    // Async reset between edges.
    apply(8'h12, 8'h34, "pre_async", 8'h46);
    #2 reset = 1'b0;
    #1 chk("async_rst", c, 8'h00);
    a = 8'd5;
    b = 8'd6;
    #1 reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("rst_edge_e1", c, (LAT == 1) ? 8'd11 : 8'd0);
    repeat (LAT - 1) tick();
    chk("rst_edge", c, 8'd11);

    // Inputs changing between edges must not reach c.
    a = 8'd1;
    b = 8'd1;
    #1 chk("stable0", c, 8'd11);
    a = 8'd7;
    b = 8'd9;
    #1 chk("stable1", c, 8'd11);
    a = 8'h20;
    b = 8'h21;
    #1 chk("stable2", c, 8'd11);
    repeat (LAT) tick();
    chk("stable_edge", c, 8'h41);

    // Random back-to-back stream; the scoreboard checks every cycle.
    repeat (1000) begin
      a = 8'($urandom_range(255, 0));
      b = 8'($urandom_range(255, 0));
      tick();
    end

    sb_on = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
